// File: rtl/demux_tdm4.sv
// Purpose : steers a time-multiplexed sample stream into per-channel A/B holding registers.
// Latency : 1 cycle from accepted sample to a_out/b_out with a_valid/b_valid set.
// Backpr. : in_ready drops when the addressed channel is still full and not acked; the source holds.
//
// Ports:
//   clk, reset        clock and synchronous active-low reset
//   in_data/in_sel    multiplexed sample and its channel tag (0 = A, 1 = B)
//   in_valid/in_ready source handshake; in_ready is combinational
//   a_out/a_valid/a_ack  channel A holding register and consumer handshake
//   b_out/b_valid/b_ack  channel B holding register and consumer handshake
//   frame_cnt         count of complete A-then-B frames (wraps)
//   frame_err/err_clr sticky ordering-violation flag and its clear

module demux_tdm4 #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] a_out,
   output logic             a_valid,
   input  logic             a_ack,
   output logic [WIDTH-1:0] b_out,
   output logic             b_valid,
   input  logic             b_ack,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             frame_err,
   input  logic             err_clr
);

   typedef enum logic {
      EXPECT_A = 1'b0,
      EXPECT_B = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   logic a_room;
   logic b_room;
   logic xfer;
   logic a_load;
   logic b_load;
   logic viol;
   logic frame_done;

   // A channel has room when empty or when its consumer is taking the
   // current word this cycle (load and drain can then happen together).
   assign a_room = ~a_valid | a_ack;
   assign b_room = ~b_valid | b_ack;

   always_comb begin
      in_ready = 1'b0;
      if (reset) begin
         in_ready = in_sel ? b_room : a_room;
      end
   end

   assign xfer   = in_valid & in_ready;
   assign a_load = xfer & ~in_sel;
   assign b_load = xfer &  in_sel;

   // ---------------------------------------------------------------
   // Frame-order FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= EXPECT_A;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------
   // Frame-order FSM: next state. Only transfers move the FSM; an
   // out-of-order sample leaves the expectation where it was.
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      if (xfer) begin
         case (state)
            EXPECT_A: if (!in_sel) state_nxt = EXPECT_B;
            EXPECT_B: if (in_sel)  state_nxt = EXPECT_A;
            default:               state_nxt = EXPECT_A;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Frame-order FSM: outputs (decoded per-transfer events)
   // ---------------------------------------------------------------
   always_comb begin
      viol       = 1'b0;
      frame_done = 1'b0;
      if (xfer) begin
         case (state)
            EXPECT_A: viol = in_sel;
            EXPECT_B: begin
               viol       = ~in_sel;
               frame_done = in_sel;
            end
            default: viol = 1'b0;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Channel A holding register. A new load takes priority over the
   // ack so a same-cycle ack+load keeps a_valid high with fresh data.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         a_out   <= '0;
         a_valid <= 1'b0;
      end else if (a_load) begin
         a_out   <= in_data;
         a_valid <= 1'b1;
      end else if (a_ack) begin
         a_valid <= 1'b0;
      end
   end

   // ---------------------------------------------------------------
   // Channel B holding register, same rules as A.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         b_out   <= '0;
         b_valid <= 1'b0;
      end else if (b_load) begin
         b_out   <= in_data;
         b_valid <= 1'b1;
      end else if (b_ack) begin
         b_valid <= 1'b0;
      end
   end

   // ---------------------------------------------------------------
   // Frame counter, free-running wrap.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         frame_cnt <= '0;
      end else if (frame_done) begin
         frame_cnt <= frame_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // Sticky ordering error. A violation in the same cycle as err_clr
   // must not be lost, so the set term is checked first.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         frame_err <= 1'b0;
      end else if (viol) begin
         frame_err <= 1'b1;
      end else if (err_clr) begin
         frame_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_demux_tdm4.sv
module tb_demux_tdm4;

   logic       clk;
   logic       reset;
   logic [3:0] in_data;
   logic       in_sel;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] a_out;
   logic       a_valid;
   logic       a_ack;
   logic [3:0] b_out;
   logic       b_valid;
   logic       b_ack;
   logic [7:0] frame_cnt;
   logic       frame_err;
   logic       err_clr;

   int n_checks = 0;
   int n_fail   = 0;

   demux_tdm4 #(.WIDTH(4), .CNT_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_out     (a_out),
      .a_valid   (a_valid),
      .a_ack     (a_ack),
      .b_out     (b_out),
      .b_valid   (b_valid),
      .b_ack     (b_ack),
      .frame_cnt (frame_cnt),
      .frame_err (frame_err),
      .err_clr   (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       vld;
      logic       sel;
      logic [3:0] dat;
      logic       aack;
      logic       back;
      logic       clr;
      logic       rdy;   // expected in_ready before the edge
      logic [3:0] aout;  // expected registered outputs after the edge
      logic       av;
      logic [3:0] bout;
      logic       bv;
      logic [7:0] cnt;
      logic       err;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs[NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic vld, input logic sel, input logic [3:0] dat,
                        input logic aack, input logic back, input logic clr);
      @(negedge clk);
      reset    = rst;
      in_valid = vld;
      in_sel   = sel;
      in_data  = dat;
      a_ack    = aack;
      b_ack    = back;
      err_clr  = clr;
   endtask

   task automatic step(input logic rst, input logic vld, input logic sel, input logic [3:0] dat,
                       input logic aack, input logic back, input logic clr);
      drive(rst, vld, sel, dat, aack, back, clr);
      @(posedge clk);
      #1;
   endtask

   initial begin
      //           rst   vld   sel   dat      aack  back  clr   rdy   aout     av    bout     bv    cnt     err
      // reset held with a sample presented
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0};
      // normal frame, acks every cycle (ack while empty is ignored)
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'b0101, 1'b1, 1'b1, 1'b0, 1'b1, 4'h5, 1'b1, 4'h0, 1'b0, 8'd0, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b1, 4'h5, 1'b0, 4'hA, 1'b1, 8'd1, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 1'b0, 4'hA, 1'b0, 8'd1, 1'b0};
      // back-pressure on A, then ack+load in the same cycle (double A -> error)
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 4'hA, 1'b0, 8'd1, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 1'b1, 4'hA, 1'b0, 8'd1, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b1, 4'hC, 1'b1, 4'hA, 1'b0, 8'd1, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'hC, 1'b0, 4'hA, 1'b0, 8'd1, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'hC, 1'b0, 4'h0, 1'b1, 8'd2, 1'b0};
      // reset clears valids and counter
      vecs[11] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0};
      // ordering error: B first from reset
      vecs[12] = '{1'b1, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 4'h1, 1'b1, 8'd0, 1'b1};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1, 4'h2, 1'b1, 4'h1, 1'b0, 8'd0, 1'b1};
      vecs[14] = '{1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 1'b0, 4'h4, 1'b1, 8'd1, 1'b1};
      vecs[15] = '{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 4'h2, 1'b0, 4'h4, 1'b0, 8'd1, 1'b0};
      // double A with err_clr in the violating cycle: violation wins
      vecs[16] = '{1'b1, 1'b1, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 4'h7, 1'b1, 4'h4, 1'b0, 8'd1, 1'b0};
      vecs[17] = '{1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 4'h4, 1'b0, 8'd1, 1'b0};
      vecs[18] = '{1'b1, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 4'h8, 1'b1, 4'h4, 1'b0, 8'd1, 1'b1};
      vecs[19] = '{1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b1, 4'h8, 1'b0, 4'h6, 1'b1, 8'd2, 1'b1};
      // B stalled; A still flows past it
      vecs[20] = '{1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8, 1'b0, 4'h6, 1'b1, 8'd2, 1'b1};
      vecs[21] = '{1'b1, 1'b1, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 4'h9, 1'b1, 4'h6, 1'b1, 8'd2, 1'b1};
      vecs[22] = '{1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 4'h9, 1'b1, 4'hF, 1'b1, 8'd3, 1'b1};

      reset = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = 4'h0;
      a_ack = 1'b0; b_ack = 1'b0; err_clr = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].rst, vecs[i].vld, vecs[i].sel, vecs[i].dat,
               vecs[i].aack, vecs[i].back, vecs[i].clr);
         #1;
         chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d a_out", i),     32'(a_out),     32'(vecs[i].aout));
         chk($sformatf("v%0d a_valid", i),   32'(a_valid),   32'(vecs[i].av));
         chk($sformatf("v%0d b_out", i),     32'(b_out),     32'(vecs[i].bout));
         chk($sformatf("v%0d b_valid", i),   32'(b_valid),   32'(vecs[i].bv));
         chk($sformatf("v%0d frame_cnt", i), 32'(frame_cnt), 32'(vecs[i].cnt));
         chk($sformatf("v%0d frame_err", i), 32'(frame_err), 32'(vecs[i].err));
      end

      // Counter wrap: 256 clean frames from reset, acks every cycle.
      step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      for (int f = 0; f < 256; f++) begin
         step(1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 1'b1, 1'b0);
         step(1'b1, 1'b1, 1'b1, 4'hC, 1'b1, 1'b1, 1'b0);
         if (f == 254) chk("wrap cnt 255", 32'(frame_cnt), 32'd255);
      end
      chk("wrap cnt 0", 32'(frame_cnt), 32'd0);
      chk("wrap err",   32'(frame_err), 32'd0);
      chk("wrap b_out", 32'(b_out),     32'hC);

      // Mid-frame reset: pending A is discarded, so the following B is out of order.
      step(1'b1, 1'b1, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0);
      chk("mid a_valid", 32'(a_valid), 32'd1);
      drive(1'b0, 1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
      #1;
      chk("mid rst in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("mid rst a_valid", 32'(a_valid), 32'd0);
      chk("mid rst b_valid", 32'(b_valid), 32'd0);
      step(1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
      chk("mid B frame_err", 32'(frame_err), 32'd1);
      chk("mid B frame_cnt", 32'(frame_cnt), 32'd0);
      chk("mid B b_out",     32'(b_out),     32'hA);
      chk("mid B b_valid",   32'(b_valid),   32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
